// File: rtl/sccb_pkg.sv
// Shared SCCB responder definitions: FSM state encoding, R/W bit position and
// direction constants, and the default 8-bit write device ID.
package sccb_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ID,
    ID_ACK,
    SUB,
    SUB_ACK,
    DATA,
    DATA_ACK,
    TX,
    TX_NA,
    IGNORE
  } sccb_state_e;

  localparam int unsigned RW_BIT            = 0;
  localparam logic        SCCB_WRITE        = 1'b0;
  localparam logic        SCCB_READ         = 1'b1;
  localparam logic [7:0]  DEFAULT_DEVICE_ID = 8'h42;

endpackage

// File: rtl/sccb_line_sync.sv
// SCCB line conditioning: synchronises SIOC/SIOD into the clk domain and
// derives SIOC edges plus START/STOP conditions.
//   clk, reset          : system clock, synchronous active-high reset
//   sioc_in, siod_in    : asynchronous bus lines
//   sioc_rise/sioc_fall : one-cycle synced SIOC edge pulses
//   start_det/stop_det  : SIOD fall/rise while SIOC is high and stable
//   siod_s              : synchronised SIOD level
module sccb_line_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic sioc_in,
  input  logic siod_in,
  output logic sioc_rise,
  output logic sioc_fall,
  output logic start_det,
  output logic stop_det,
  output logic siod_s
);

  logic [SYNC_STAGES-1:0] sioc_sync_q;
  logic [SYNC_STAGES-1:0] siod_sync_q;
  logic                   sioc_prev_q;
  logic                   siod_prev_q;
  logic                   sioc_s;

  // Released bus idles high, so reset to '1 to avoid phantom edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      sioc_sync_q <= '1;
      siod_sync_q <= '1;
      sioc_prev_q <= 1'b1;
      siod_prev_q <= 1'b1;
    end else begin
      sioc_sync_q <= {sioc_sync_q[SYNC_STAGES-2:0], sioc_in};
      siod_sync_q <= {siod_sync_q[SYNC_STAGES-2:0], siod_in};
      sioc_prev_q <= sioc_sync_q[SYNC_STAGES-1];
      siod_prev_q <= siod_sync_q[SYNC_STAGES-1];
    end
  end

  assign sioc_s    = sioc_sync_q[SYNC_STAGES-1];
  assign siod_s    = siod_sync_q[SYNC_STAGES-1];
  assign sioc_rise =  sioc_s & ~sioc_prev_q;
  assign sioc_fall = ~sioc_s &  sioc_prev_q;
  // Requiring SIOC high in both the current and previous sample means a
  // simultaneous SIOC/SIOD change is seen only as an SIOC edge.
  assign start_det = sioc_s & sioc_prev_q &  siod_prev_q & ~siod_s;
  assign stop_det  = sioc_s & sioc_prev_q & ~siod_prev_q &  siod_s;

endmodule

// File: rtl/sccb_responder.sv
// SCCB target: decodes 3-phase writes and 2-phase write/read transactions,
// stores written bytes in a 256x8 shadow register file and returns shadow
// contents on reads.
//   clk, reset         : system clock (>= 16x SIOC), synchronous active-high reset
//   sioc_in, siod_in   : asynchronous SCCB clock / data as seen at the pad
//   siod_oe            : 1 = pull SIOD low (open-drain)
//   wr_strobe          : one-cycle pulse per committed data byte
//   wr_addr, wr_data   : address/data of the last committed byte
//   sub_addr           : current sub-address pointer
//   busy               : FSM not in IDLE
module sccb_responder
  import sccb_pkg::*;
#(
  parameter logic [7:0]  DEVICE_ID   = DEFAULT_DEVICE_ID,
  parameter bit          ACK_DRIVE   = 1'b1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sioc_in,
  input  logic       siod_in,
  output logic       siod_oe,
  output logic       wr_strobe,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [7:0] sub_addr,
  output logic       busy
);

  logic sioc_rise, sioc_fall, start_det, stop_det, siod_s;

  sccb_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .reset    (reset),
    .sioc_in  (sioc_in),
    .siod_in  (siod_in),
    .sioc_rise(sioc_rise),
    .sioc_fall(sioc_fall),
    .start_det(start_det),
    .stop_det (stop_det),
    .siod_s   (siod_s)
  );

  sccb_state_e state_q;
  logic [3:0]  bitcnt_q;
  logic [7:0]  shift_q;
  logic [7:0]  tx_q;
  logic        rw_q;
  logic        ack_phase_q;
  logic        siod_oe_q;
  logic        wr_strobe_q;
  logic [7:0]  wr_addr_q;
  logic [7:0]  wr_data_q;
  logic [7:0]  sub_addr_q;
  logic [7:0]  shadow_q [256];

  logic [7:0]  rx_byte;
  logic [7:0]  shadow_rd;

  assign rx_byte   = {shift_q[6:0], siod_s};
  assign shadow_rd = shadow_q[sub_addr_q];

  // Shadow is committed from the registered strobe, one cycle after the
  // event is reported; it is never reset.
  always_ff @(posedge clk) begin
    if (wr_strobe_q) shadow_q[wr_addr_q] <= wr_data_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      bitcnt_q    <= '0;
      shift_q     <= '0;
      tx_q        <= '0;
      rw_q        <= SCCB_WRITE;
      ack_phase_q <= 1'b0;
      siod_oe_q   <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      sub_addr_q  <= '0;
    end else begin
      wr_strobe_q <= 1'b0;
      if (start_det) begin
        state_q     <= ID;
        bitcnt_q    <= '0;
        ack_phase_q <= 1'b0;
        siod_oe_q   <= 1'b0;
      end else if (stop_det) begin
        state_q     <= IDLE;
        bitcnt_q    <= '0;
        ack_phase_q <= 1'b0;
        siod_oe_q   <= 1'b0;
      end else begin
        if (sioc_rise) shift_q <= rx_byte;
        unique case (state_q)
          IDLE: ;
          ID, SUB, DATA: begin
            if (sioc_rise) begin
              bitcnt_q <= bitcnt_q + 4'd1;
              if (bitcnt_q == 4'd7) begin
                bitcnt_q <= '0;
                if (state_q == ID) begin
                  if (rx_byte[7:1] == DEVICE_ID[7:1]) begin
                    rw_q    <= rx_byte[RW_BIT];
                    state_q <= ID_ACK;
                  end else begin
                    state_q <= IGNORE;
                  end
                end else if (state_q == SUB) begin
                  sub_addr_q <= rx_byte;
                  state_q    <= SUB_ACK;
                end else begin
                  wr_strobe_q <= 1'b1;
                  wr_addr_q   <= sub_addr_q;
                  wr_data_q   <= rx_byte;
                  state_q     <= DATA_ACK;
                end
              end
            end
          end
          // First fall opens the ACK slot, second fall closes it.
          ID_ACK, SUB_ACK, DATA_ACK: begin
            if (sioc_fall) begin
              if (!ack_phase_q) begin
                siod_oe_q   <= ACK_DRIVE;
                ack_phase_q <= 1'b1;
              end else begin
                ack_phase_q <= 1'b0;
                siod_oe_q   <= 1'b0;
                if (state_q == ID_ACK && rw_q == SCCB_READ) begin
                  siod_oe_q <= ~shadow_rd[7];
                  tx_q      <= {shadow_rd[6:0], 1'b0};
                  bitcnt_q  <= 4'd1;
                  state_q   <= TX;
                end else if (state_q == ID_ACK) begin
                  state_q <= SUB;
                end else if (state_q == SUB_ACK) begin
                  state_q <= DATA;
                end else begin
                  state_q <= IGNORE;
                end
              end
            end
          end
          TX: begin
            if (sioc_fall) begin
              if (bitcnt_q < 4'd8) begin
                siod_oe_q <= ~tx_q[7];
                tx_q      <= {tx_q[6:0], 1'b0};
                bitcnt_q  <= bitcnt_q + 4'd1;
              end else begin
                siod_oe_q <= 1'b0;
                bitcnt_q  <= '0;
                state_q   <= TX_NA;
              end
            end
          end
          TX_NA: begin
            if (sioc_rise) state_q <= IGNORE;
          end
          IGNORE: siod_oe_q <= 1'b0;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign siod_oe   = siod_oe_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign sub_addr  = sub_addr_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_sccb_responder.sv
`timescale 1ns/100ps
module tb_sccb_responder;

  logic       clk = 1'b0;
  logic       reset;
  logic       sioc_m, siod_m;
  logic       siod_line;
  logic       siod_oe, wr_strobe, busy;
  logic [7:0] wr_addr, wr_data, sub_addr;

  // Open-drain pad: master and responder both only pull low.
  assign siod_line = siod_m & ~siod_oe;

  always #19.9 clk = ~clk;  // ~25.125 MHz

  sccb_responder #(.DEVICE_ID(8'h42), .ACK_DRIVE(1'b1), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .sioc_in  (sioc_m),
    .siod_in  (siod_line),
    .siod_oe  (siod_oe),
    .wr_strobe(wr_strobe),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .sub_addr (sub_addr),
    .busy     (busy)
  );

  int checks = 0;
  int errors = 0;
  real hp = 5000.0;  // SIOC half period (ns)

  typedef struct packed {logic [7:0] addr; logic [7:0] data;} wr_t;
  wr_t exp_q[$];

  task automatic check8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: every strobe must match the next expected write.
  always @(negedge clk) begin : mon
    wr_t e;
    if (wr_strobe === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got addr %h data %h expected no strobe", wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        check8("strobe_addr", wr_addr, e.addr);
        check8("strobe_data", wr_data, e.data);
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  task automatic bus_start();
    siod_m = 1'b1; sioc_m = 1'b1;
    #(hp); siod_m = 1'b0;
    #(hp); sioc_m = 1'b0;
  endtask

  task automatic bus_rstart();
    #(hp/4) siod_m = 1'b1;
    #(hp*3/4) sioc_m = 1'b1;
    #(hp/2) siod_m = 1'b0;
    #(hp/2) sioc_m = 1'b0;
  endtask

  // One SIOC period; returns siod_oe sampled mid-high.
  task automatic bus_bit(input logic b, output logic oe_seen);
    #(hp/4) siod_m = b;
    #(hp*3/4) sioc_m = 1'b1;
    #(hp/2);
    @(negedge clk) oe_seen = siod_oe;
    #(hp/2) sioc_m = 1'b0;
  endtask

  // Returns number of clk edges from SIOD rise until busy drops.
  task automatic bus_stop(output int n);
    #(hp/4) siod_m = 1'b0;
    #(hp*3/4) sioc_m = 1'b1;
    #(hp/2);
    @(negedge clk) siod_m = 1'b1;
    n = 0;
    while (busy && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    #(hp);
  endtask

  task automatic xfer(input logic [7:0] b, input logic exp_ack, input string nm);
    logic a, o, oe_any;
    oe_any = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(b[i], o);
      oe_any |= o;
    end
    bus_bit(1'b1, a);
    check8({nm, "_ack"}, {7'd0, a}, {7'd0, exp_ack});
    check8({nm, "_oe_bits"}, {7'd0, oe_any}, 8'd0);
  endtask

  task automatic rd(input logic [7:0] exp_pat, input string nm);
    logic [7:0] pat;
    logic o;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, o);
      pat[i] = o;
    end
    bus_bit(1'b1, o);
    check8({nm, "_oe_pattern"}, pat, exp_pat);
    check8({nm, "_na_oe"}, {7'd0, o}, 8'd0);
  endtask

  initial begin
    int n;
    logic o;
    reset = 1'b1; sioc_m = 1'b1; siod_m = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    check8("rst_siod_oe", {7'd0, siod_oe}, 8'd0);
    check8("rst_wr_strobe", {7'd0, wr_strobe}, 8'd0);
    check8("rst_wr_addr", wr_addr, 8'h00);
    check8("rst_wr_data", wr_data, 8'h00);
    check8("rst_sub_addr", sub_addr, 8'h00);
    check8("rst_busy", {7'd0, busy}, 8'd0);

    // 3-phase write at 100 kHz
    bus_start();
    xfer(8'h42, 1'b1, "t1_id");
    xfer(8'h12, 1'b1, "t1_sub");
    exp_q.push_back(wr_t'{addr: 8'h12, data: 8'h80});
    xfer(8'h80, 1'b1, "t1_data");
    bus_stop(n);
    check8("t1_busy_latency", 8'(n), 8'd3);
    check8("t1_sub_addr", sub_addr, 8'h12);
    check8("t1_sb_empty", 8'(exp_q.size()), 8'd0);

    hp = 640.0;  // 32 clk per SIOC period from here on

    // Wrong ID: ignored until STOP
    bus_start();
    xfer(8'h60, 1'b0, "t2_id");
    xfer(8'h55, 1'b0, "t2_b1");
    xfer(8'hAA, 1'b0, "t2_b2");
    check8("t2_busy_ignore", {7'd0, busy}, 8'd1);
    bus_stop(n);
    check8("t2_busy_after", {7'd0, busy}, 8'd0);
    check8("t2_sub_addr", sub_addr, 8'h12);

    // Readback: write 3A=04, 2-phase pointer set, then read
    bus_start();
    xfer(8'h42, 1'b1, "t3_id");
    xfer(8'h3A, 1'b1, "t3_sub");
    exp_q.push_back(wr_t'{addr: 8'h3A, data: 8'h04});
    xfer(8'h04, 1'b1, "t3_data");
    bus_stop(n);
    bus_start();
    xfer(8'h42, 1'b1, "t3_id2");
    xfer(8'h3A, 1'b1, "t3_sub2");
    bus_stop(n);
    check8("t3_sub_addr_set", sub_addr, 8'h3A);
    bus_start();
    xfer(8'h43, 1'b1, "t3_rid");
    rd(8'hFB, "t3_rd");
    bus_stop(n);
    check8("t3_sub_addr_kept", sub_addr, 8'h3A);

    // Repeated start read of 1E
    bus_start();
    xfer(8'h42, 1'b1, "t4_wid");
    xfer(8'h1E, 1'b1, "t4_wsub");
    exp_q.push_back(wr_t'{addr: 8'h1E, data: 8'h5C});
    xfer(8'h5C, 1'b1, "t4_wdata");
    bus_stop(n);
    bus_start();
    xfer(8'h42, 1'b1, "t4_id");
    xfer(8'h1E, 1'b1, "t4_sub");
    bus_rstart();
    xfer(8'h43, 1'b1, "t4_rid");
    rd(8'hA3, "t4_rd");
    bus_stop(n);
    check8("t4_sb_empty", 8'(exp_q.size()), 8'd0);

    // Abort: STOP after 5 DATA bits leaves shadow[20] intact
    bus_start();
    xfer(8'h42, 1'b1, "t5_wid");
    xfer(8'h20, 1'b1, "t5_wsub");
    exp_q.push_back(wr_t'{addr: 8'h20, data: 8'hC3});
    xfer(8'hC3, 1'b1, "t5_wdata");
    bus_stop(n);
    bus_start();
    xfer(8'h42, 1'b1, "t5_id");
    xfer(8'h20, 1'b1, "t5_sub");
    bus_bit(1'b1, o); bus_bit(1'b0, o); bus_bit(1'b1, o);
    bus_bit(1'b1, o); bus_bit(1'b1, o);
    bus_stop(n);
    bus_start();
    xfer(8'h42, 1'b1, "t5_id2");
    xfer(8'h20, 1'b1, "t5_sub2");
    bus_rstart();
    xfer(8'h43, 1'b1, "t5_rid");
    rd(8'h3C, "t5_rd");
    bus_stop(n);

    // Reset during TX (shadow[20]=C3, 3rd/4th TX bits drive low)
    bus_start();
    xfer(8'h43, 1'b1, "t6_rid");
    for (int i = 0; i < 3; i++) bus_bit(1'b1, o);
    #(hp/2);
    @(negedge clk);
    check8("t6_oe_before_rst", {7'd0, siod_oe}, 8'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    check8("t6_rst_oe", {7'd0, siod_oe}, 8'd0);
    check8("t6_rst_sub_addr", sub_addr, 8'h00);
    check8("t6_rst_busy", {7'd0, busy}, 8'd0);
    @(negedge clk) reset = 1'b0;
    sioc_m = 1'b1;
    #(hp) siod_m = 1'b1;
    #(hp);
    check8("t6_idle_busy", {7'd0, busy}, 8'd0);

    // Extra 4th byte is ignored
    bus_start();
    xfer(8'h42, 1'b1, "t7_id");
    xfer(8'h11, 1'b1, "t7_sub");
    exp_q.push_back(wr_t'{addr: 8'h11, data: 8'h01});
    xfer(8'h01, 1'b1, "t7_data");
    xfer(8'hFF, 1'b0, "t7_extra");
    bus_stop(n);
    bus_start();
    xfer(8'h42, 1'b1, "t7_id2");
    xfer(8'h12, 1'b1, "t7_sub2");
    bus_rstart();
    xfer(8'h43, 1'b1, "t7_rid");
    rd(8'h7F, "t7_rd");
    bus_stop(n);
    check8("t7_sub_addr", sub_addr, 8'h12);
    check8("final_sb_empty", 8'(exp_q.size()), 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
